// File: rtl/video_dnn_argmax_detect_if.sv
// AXI4-Stream style bus carrying per-pixel class votes and the argmax result.
interface video_dnn_argmax_detect_if #(
   parameter int unsigned NUM_CLASS     = 11,
   parameter int unsigned CHANNEL_WIDTH = 4,
   parameter int unsigned TUSER_WIDTH   = 1,
   parameter int unsigned TNUMBER_WIDTH = 4,
   parameter int unsigned TCOUNT_WIDTH  = 4
);
   localparam int unsigned DATA_W = NUM_CLASS * CHANNEL_WIDTH;

   logic [TUSER_WIDTH-1:0]   tuser;
   logic                     tlast;
   logic [TNUMBER_WIDTH-1:0] tnumber;
   logic [TCOUNT_WIDTH-1:0]  tcount;
   logic [DATA_W-1:0]        tdata;
   logic                     tdetection;
   logic                     tvalid;
   logic                     tready;

   // Result stream producer
   modport master (
      output tuser, tlast, tnumber, tcount, tdata, tdetection, tvalid,
      input  tready
   );

   // Vote stream consumer
   modport slave (
      input  tuser, tlast, tdetection, tdata, tvalid,
      output tready
   );
endinterface

// File: rtl/video_dnn_argmax_detect.sv
// Per-pixel vote popcount, masked argmax with tie policy, and threshold
// detection in a two-stage stallable pipeline.
module video_dnn_argmax_detect #(
   parameter int unsigned NUM_CLASS     = 11,
   parameter int unsigned CHANNEL_WIDTH = 4,
   parameter int unsigned TUSER_WIDTH   = 1,
   parameter int unsigned TNUMBER_WIDTH = 4,
   parameter int unsigned TCOUNT_WIDTH  = 4,
   parameter logic [TCOUNT_WIDTH-1:0] INIT_PARAM_TH   = TCOUNT_WIDTH'(1),
   parameter logic [NUM_CLASS-1:0]    INIT_PARAM_MASK = '1,
   parameter logic                    INIT_PARAM_TIE  = 1'b0
) (
   input  logic                    aresetn,
   input  logic                    aclk,
   input  logic [TCOUNT_WIDTH-1:0] param_th,
   input  logic [NUM_CLASS-1:0]    param_mask,
   input  logic                    param_tie,
   video_dnn_argmax_detect_if.slave  s_axi4s,
   video_dnn_argmax_detect_if.master m_axi4s
);
   localparam int unsigned DATA_W = NUM_CLASS * CHANNEL_WIDTH;

   logic cke;
   logic frame_start;

   // Parameters currently in force for the frame
   logic [TCOUNT_WIDTH-1:0] act_th;
   logic [NUM_CLASS-1:0]    act_mask;
   logic                    act_tie;

   // Parameters that apply to the beat at the input (a frame start uses the new ones)
   logic [TCOUNT_WIDTH-1:0] eff_th;
   logic [NUM_CLASS-1:0]    eff_mask;
   logic                    eff_tie;

   logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0] cnt_c;

   // Stage 1 registers
   logic                                   v1;
   logic [TUSER_WIDTH-1:0]                 tuser1;
   logic                                   tlast1;
   logic                                   tdet1;
   logic [DATA_W-1:0]                      tdata1;
   logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0] cnt1;
   logic [TCOUNT_WIDTH-1:0]                th1;
   logic [NUM_CLASS-1:0]                   mask1;
   logic                                   tie1;

   // Stage 2 combinational argmax
   logic                     found_c;
   logic [TNUMBER_WIDTH-1:0] best_idx_c;
   logic [TCOUNT_WIDTH-1:0]  best_cnt_c;
   logic                     det_c;

   assign cke            = !m_axi4s.tvalid || m_axi4s.tready;
   assign s_axi4s.tready = cke;
   assign frame_start    = s_axi4s.tvalid && cke && s_axi4s.tuser[0];

   assign eff_th   = s_axi4s.tuser[0] ? param_th   : act_th;
   assign eff_mask = s_axi4s.tuser[0] ? param_mask : act_mask;
   assign eff_tie  = s_axi4s.tuser[0] ? param_tie  : act_tie;

   // Latch new parameters on an accepted frame-start beat
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         act_th   <= INIT_PARAM_TH;
         act_mask <= INIT_PARAM_MASK;
         act_tie  <= INIT_PARAM_TIE;
      end else if (frame_start) begin
         act_th   <= param_th;
         act_mask <= param_mask;
         act_tie  <= param_tie;
      end
   end

   // Popcount of each class vote field
   always_comb begin
      cnt_c = '0;
      for (int unsigned k = 0; k < NUM_CLASS; k++) begin
         for (int unsigned b = 0; b < CHANNEL_WIDTH; b++) begin
            cnt_c[k] = cnt_c[k] + TCOUNT_WIDTH'(s_axi4s.tdata[k*CHANNEL_WIDTH + b]);
         end
      end
   end

   // Stage 1: counts, sideband and the parameters this beat was accepted with
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v1     <= 1'b0;
         tuser1 <= '0;
         tlast1 <= 1'b0;
         tdet1  <= 1'b0;
         tdata1 <= '0;
         cnt1   <= '0;
         th1    <= '0;
         mask1  <= '0;
         tie1   <= 1'b0;
      end else if (cke) begin
         v1     <= s_axi4s.tvalid;
         tuser1 <= s_axi4s.tuser;
         tlast1 <= s_axi4s.tlast;
         tdet1  <= s_axi4s.tdetection;
         tdata1 <= s_axi4s.tdata;
         cnt1   <= cnt_c;
         th1    <= eff_th;
         mask1  <= eff_mask;
         tie1   <= eff_tie;
      end
   end

   // Masked argmax; ascending scan so '>' keeps lowest and '>=' keeps highest on ties
   always_comb begin
      found_c    = 1'b0;
      best_idx_c = '0;
      best_cnt_c = '0;
      for (int unsigned k = 0; k < NUM_CLASS; k++) begin
         if (mask1[k] && (!found_c || (cnt1[k] > best_cnt_c) ||
                          (tie1 && (cnt1[k] == best_cnt_c)))) begin
            found_c    = 1'b1;
            best_idx_c = TNUMBER_WIDTH'(k);
            best_cnt_c = cnt1[k];
         end
      end
      det_c = tdet1 && found_c && (best_cnt_c >= th1);
   end

   // Stage 2: registered result stream
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axi4s.tvalid     <= 1'b0;
         m_axi4s.tuser      <= '0;
         m_axi4s.tlast      <= 1'b0;
         m_axi4s.tnumber    <= '0;
         m_axi4s.tcount     <= '0;
         m_axi4s.tdata      <= '0;
         m_axi4s.tdetection <= 1'b0;
      end else if (cke) begin
         m_axi4s.tvalid     <= v1;
         m_axi4s.tuser      <= tuser1;
         m_axi4s.tlast      <= tlast1;
         m_axi4s.tnumber    <= best_idx_c;
         m_axi4s.tcount     <= best_cnt_c;
         m_axi4s.tdata      <= tdata1;
         m_axi4s.tdetection <= det_c;
      end
   end
endmodule

// File: tb/tb_video_dnn_argmax_detect.sv
// Directed and random-backpressure bench with a scoreboard model of the argmax detector.
module tb_video_dnn_argmax_detect;
   localparam logic [3:0]  INIT_TH   = 4'd1;
   localparam logic [10:0] INIT_MASK = 11'h7FF;
   localparam logic        INIT_TIE  = 1'b0;

   typedef struct packed {
      logic [3:0]  num;
      logic [3:0]  cnt;
      logic        det;
      logic        usr;
      logic        last;
      logic [43:0] data;
   } exp_t;

   logic        aclk;
   logic        aresetn;
   logic [3:0]  param_th;
   logic [10:0] param_mask;
   logic        param_tie;
   logic        rnd_mode;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   logic [3:0]  mact_th;
   logic [10:0] mact_mask;
   logic        mact_tie;

   video_dnn_argmax_detect_if s_if ();
   video_dnn_argmax_detect_if m_if ();

   video_dnn_argmax_detect dut (
      .aresetn    (aresetn),
      .aclk       (aclk),
      .param_th   (param_th),
      .param_mask (param_mask),
      .param_tie  (param_tie),
      .s_axi4s    (s_if),
      .m_axi4s    (m_if)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: max eligible popcount, then lowest or highest index holding it
   function automatic exp_t model(input logic [43:0] d, input logic [10:0] mask,
                                  input logic tie, input logic [3:0] th, input logic det_in,
                                  input logic usr, input logic last);
      int c[11];
      int best;
      int first;
      int lastk;
      exp_t e;
      best  = -1;
      first = -1;
      lastk = -1;
      for (int k = 0; k < 11; k++) begin
         c[k] = $countones(d[k*4 +: 4]);
         if (mask[k] && c[k] > best) best = c[k];
      end
      for (int k = 0; k < 11; k++) begin
         if (mask[k] && c[k] == best) begin
            if (first < 0) first = k;
            lastk = k;
         end
      end
      e.usr  = usr;
      e.last = last;
      e.data = d;
      if (best < 0) begin
         e.num = 4'd0;
         e.cnt = 4'd0;
         e.det = 1'b0;
      end else begin
         e.num = 4'(tie ? lastk : first);
         e.cnt = 4'(best);
         e.det = det_in && (best >= int'(th));
      end
      return e;
   endfunction

   function automatic logic [43:0] fill(input logic [3:0] v);
      logic [43:0] d;
      for (int k = 0; k < 11; k++) d[k*4 +: 4] = v;
      return d;
   endfunction

   // Output-side ready: always ready, or 30% random
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(negedge aclk);
         m_if.tready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Compare process: model input acceptances, check every output transfer and stalls
   initial begin
      exp_t e;
      exp_t snap;
      logic hold;
      hold = 1'b0;
      snap = '0;
      forever begin
         @(negedge aclk);
         #1;
         if (!aresetn) begin
            exp_q.delete();
            mact_th   = INIT_TH;
            mact_mask = INIT_MASK;
            mact_tie  = INIT_TIE;
            hold      = 1'b0;
            chk("reset_tvalid", 64'(m_if.tvalid), 64'(0));
         end else begin
            if (hold) begin
               chk("stall_stable", 64'({m_if.tvalid, m_if.tnumber, m_if.tcount, m_if.tdetection,
                                         m_if.tuser, m_if.tlast, m_if.tdata}),
                   64'({1'b1, snap}));
            end
            if (m_if.tvalid && m_if.tready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_beat", 64'(1), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("tnumber", 64'(m_if.tnumber), 64'(e.num));
                  chk("tcount", 64'(m_if.tcount), 64'(e.cnt));
                  chk("tdetection", 64'(m_if.tdetection), 64'(e.det));
                  chk("tuser", 64'(m_if.tuser), 64'(e.usr));
                  chk("tlast", 64'(m_if.tlast), 64'(e.last));
                  chk("tdata", 64'(m_if.tdata), 64'(e.data));
               end
            end
            hold = m_if.tvalid && !m_if.tready;
            snap = {m_if.tnumber, m_if.tcount, m_if.tdetection, m_if.tuser, m_if.tlast, m_if.tdata};
            if (s_if.tvalid && s_if.tready) begin
               if (s_if.tuser[0]) begin
                  mact_th   = param_th;
                  mact_mask = param_mask;
                  mact_tie  = param_tie;
               end
               exp_q.push_back(model(s_if.tdata, mact_mask, mact_tie, mact_th,
                                     s_if.tdetection, s_if.tuser[0], s_if.tlast));
            end
         end
      end
   end

   // Present a beat at a negedge and hold it until accepted; returns at a negedge
   task automatic send(input logic [43:0] d, input logic usr, input logic last, input logic det);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      s_if.tdata      = d;
      s_if.tuser      = usr;
      s_if.tlast      = last;
      s_if.tdetection = det;
      s_if.tvalid     = 1'b1;
      while (!acc && n < 500) begin
         #2;
         acc = s_if.tready;
         @(negedge aclk);
         n++;
      end
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle(input int n);
      s_if.tvalid = 1'b0;
      repeat (n) @(negedge aclk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [43:0] d;
      logic [63:0] r;
      exp_t e;

      rnd_mode        = 1'b0;
      aresetn         = 1'b0;
      param_th        = 4'd1;
      param_mask      = 11'h7FF;
      param_tie       = 1'b0;
      s_if.tvalid     = 1'b0;
      s_if.tdata      = '0;
      s_if.tuser      = '0;
      s_if.tlast      = 1'b0;
      s_if.tdetection = 1'b0;
      s_if.tnumber    = '0;
      s_if.tcount     = '0;
      repeat (3) @(negedge aclk);
      #1;
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("rst_s_tready", 64'(s_if.tready), 64'(1));
      chk("rst_tnumber", 64'(m_if.tnumber), 64'(0));
      @(negedge aclk);
      aresetn = 1'b1;

      // Class 3 saturated, rest one vote
      d = fill(4'h1);
      d[12 +: 4] = 4'hF;
      e = model(d, 11'h7FF, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("pin26", 64'({e.num, e.cnt, e.det}), 64'({4'd3, 4'd4, 1'b1}));
      send(d, 1'b1, 1'b0, 1'b1);
      s_if.tvalid = 1'b0;
      #1;
      chk("lat26_stage1", 64'(m_if.tvalid), 64'(0));
      @(negedge aclk);
      #1;
      chk("lat26_out", 64'({m_if.tvalid, m_if.tnumber, m_if.tcount, m_if.tdetection}),
          64'({1'b1, 4'd3, 4'd4, 1'b1}));
      @(negedge aclk);

      // Tie between classes 2 and 7
      d = '0;
      d[8 +: 4]  = 4'h7;
      d[28 +: 4] = 4'h7;
      e = model(d, 11'h7FF, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("pin27_tie0", 64'({e.num, e.cnt}), 64'({4'd2, 4'd3}));
      e = model(d, 11'h7FF, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("pin27_tie1", 64'({e.num, e.cnt}), 64'({4'd7, 4'd3}));
      param_tie = 1'b0;
      send(d, 1'b1, 1'b1, 1'b1);
      param_tie = 1'b1;
      send(d, 1'b1, 1'b1, 1'b1);
      idle(3);

      // Masked-out winner, then nothing eligible
      d = '0;
      d[12 +: 4] = 4'hF;
      d[20 +: 4] = 4'h3;
      e = model(d, 11'h7F7, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("pin28_mask", 64'({e.num, e.cnt}), 64'({4'd5, 4'd2}));
      e = model(d, 11'h000, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("pin28_none", 64'({e.num, e.cnt, e.det}), 64'({4'd0, 4'd0, 1'b0}));
      param_tie  = 1'b0;
      param_mask = 11'h7F7;
      send(d, 1'b1, 1'b0, 1'b1);
      param_mask = 11'h000;
      send(d, 1'b1, 1'b0, 1'b1);
      idle(3);

      // Threshold above winner count; later change without frame start is ignored
      param_mask = 11'h7FF;
      d = '0;
      d[20 +: 4] = 4'h3;
      e = model(d, 11'h7FF, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
      chk("pin29_th", 64'({e.num, e.cnt, e.det}), 64'({4'd5, 4'd2, 1'b0}));
      param_th = 4'd3;
      send(d, 1'b1, 1'b0, 1'b1);
      param_th = 4'd1;
      send(d, 1'b0, 1'b0, 1'b1);
      send(d, 1'b1, 1'b0, 1'b1);
      e = model(44'd0, 11'h7FF, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk("pin_th0", 64'({e.num, e.cnt, e.det}), 64'({4'd0, 4'd0, 1'b1}));
      param_th = 4'd0;
      send(44'd0, 1'b1, 1'b0, 1'b1);
      idle(4);

      // Continuous random traffic under 30% output ready
      rnd_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         r = {$urandom(), $urandom()};
         param_th   = 4'($urandom_range(0, 5));
         param_mask = 11'($urandom());
         param_tie  = 1'($urandom());
         send(r[43:0], ($urandom_range(0, 19) == 0), (i % 8 == 7), 1'($urandom()));
      end
      idle(2);
      rnd_mode = 1'b0;
      idle(10);
      chk("drain_empty", 64'(exp_q.size()), 64'(0));

      // Reset with two beats in flight; parameters must return to their reset values
      param_th   = 4'd5;
      param_mask = 11'h000;
      param_tie  = 1'b1;
      d = fill(4'h1);
      d[12 +: 4] = 4'hF;
      send(d, 1'b1, 1'b0, 1'b1);
      send(d, 1'b0, 1'b0, 1'b1);
      send(d, 1'b0, 1'b1, 1'b1);
      s_if.tvalid = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_rst_tvalid", 64'(m_if.tvalid), 64'(0));
      chk("async_rst_tready", 64'(s_if.tready), 64'(1));
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      send(d, 1'b0, 1'b0, 1'b1);
      s_if.tvalid = 1'b0;
      #1;
      chk("post_rst_no_stale", 64'(m_if.tvalid), 64'(0));
      @(negedge aclk);
      #1;
      chk("post_rst_init_params", 64'({m_if.tvalid, m_if.tnumber, m_if.tcount, m_if.tdetection}),
          64'({1'b1, 4'd3, 4'd4, 1'b1}));
      @(negedge aclk);
      idle(4);
      chk("final_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
